// File: rtl/morse_decoder.sv
// Morse receive decoder: run-length classifies marks into dots and dashes and decodes letters A..H.
// Defining MORSE_DEC_STRICT_GAP_EN turns a two-zero gap inside a letter into a letter error.
module morse_decoder #(
  parameter int CLOCK_FREQUENCY = 100,
  parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       DotDashIn,
  input  logic       NewBitIn,
  output logic [2:0] LetterOut,
  output logic       LetterValid,
  output logic       LetterError,
  output logic       Busy
);

  localparam int            IW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IdleLast = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IdleMax  = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    mark_q, mark_d;
  logic [1:0]    space_q, space_d;
  logic [2:0]    symcnt_q, symcnt_d;
  logic [3:0]    sym_q, sym_d;
  logic          err_q, err_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [2:0]    letter_q, letter_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic [2:0] pcnt;
  logic [3:0] psym;
  logic       perr;
  logic       timeout;
  logic       fin;
  logic [2:0] fcnt;
  logic [3:0] fsym;
  logic       ferr;
  logic [2:0] code;
  logic       hit;

  assign timeout = (state_q != IDLE) && !NewBitIn && (idle_q == IdleLast);

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Symbol state after closing the open mark run; shared by a 0 strobe and a MARK timeout.
  always_comb begin
    pcnt = symcnt_q;
    psym = sym_q;
    perr = err_q;
    if (!(mark_q == 3'd1 || mark_q == 3'd3)) perr = 1'b1;
    if (symcnt_q < 3'd4) begin
      pcnt = symcnt_q + 3'd1;
      psym = {sym_q[2:0], (mark_q == 3'd3)};
    end else begin
      perr = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mark_d   = mark_q;
    space_d  = space_q;
    symcnt_d = symcnt_q;
    sym_d    = sym_q;
    err_d    = err_q;
    fin      = 1'b0;
    fcnt     = symcnt_q;
    fsym     = sym_q;
    ferr     = err_q;
    if (NewBitIn || state_q == IDLE) idle_d = '0;
    else if (idle_q != IdleMax)      idle_d = idle_q + IW'(1);
    else                             idle_d = idle_q;
    case (state_q)
      IDLE: begin
        if (NewBitIn && DotDashIn) begin
          state_d = MARK;
          mark_d  = 3'd1;
        end
      end
      MARK: begin
        if (NewBitIn) begin
          if (DotDashIn) begin
            if (mark_q != 3'd4) mark_d = mark_q + 3'd1;
          end else begin
            symcnt_d = pcnt;
            sym_d    = psym;
            err_d    = perr;
            space_d  = 2'd1;
            state_d  = SPACE;
          end
        end else if (timeout) begin
          fin  = 1'b1;
          fcnt = pcnt;
          fsym = psym;
          ferr = perr;
        end
      end
      SPACE: begin
        if (NewBitIn) begin
          if (DotDashIn) begin
            state_d = MARK;
            mark_d  = 3'd1;
`ifdef MORSE_DEC_STRICT_GAP_EN
            if (space_q == 2'd2) err_d = 1'b1;
`endif
          end else if (space_q == 2'd2) begin
            fin = 1'b1;
          end else begin
            space_d = space_q + 2'd1;
          end
        end else if (timeout) begin
          fin = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d  = IDLE;
      mark_d   = '0;
      space_d  = '0;
      symcnt_d = '0;
      sym_d    = '0;
      err_d    = 1'b0;
      idle_d   = '0;
    end
  end

  // Pattern is right-aligned: the first symbol sits in bit (length-1), dash = 1.
  always_comb begin
    hit  = 1'b0;
    code = 3'b000;
    case (fcnt)
      3'd1: if (fsym[0] == 1'b0)      begin hit = 1'b1; code = 3'b100; end
      3'd2: if (fsym[1:0] == 2'b01)   begin hit = 1'b1; code = 3'b000; end
      3'd3: begin
        case (fsym[2:0])
          3'b100:  begin hit = 1'b1; code = 3'b011; end
          3'b110:  begin hit = 1'b1; code = 3'b110; end
          default: ;
        endcase
      end
      3'd4: begin
        case (fsym)
          4'b1000: begin hit = 1'b1; code = 3'b001; end
          4'b1010: begin hit = 1'b1; code = 3'b010; end
          4'b0010: begin hit = 1'b1; code = 3'b101; end
          4'b0000: begin hit = 1'b1; code = 3'b111; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (fin) begin
      if (ferr || !hit) begin
        error_d = 1'b1;
      end else begin
        valid_d  = 1'b1;
        letter_d = code;
      end
    end
    Busy        = (state_q != IDLE);
    LetterOut   = letter_q;
    LetterValid = valid_q;
    LetterError = error_q;
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      mark_q   <= '0;
      space_q  <= '0;
      symcnt_q <= '0;
      sym_q    <= '0;
      err_q    <= 1'b0;
      idle_q   <= '0;
      letter_q <= 3'b000;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      mark_q   <= mark_d;
      space_q  <= space_d;
      symcnt_q <= symcnt_d;
      sym_q    <= sym_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Testbench for morse_decoder: directed scenarios plus random letters, checked every cycle
// against a symbol-string reference model.
module tb_morse_decoder;

  localparam int T = 12;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       LetterError;
  logic       Busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  morse_decoder #(.CLOCK_FREQUENCY(T), .TIMEOUT_CYCLES(T)) dut (
    .ClockIn    (clk),
    .Resetn     (Resetn),
    .DotDashIn  (DotDashIn),
    .NewBitIn   (NewBitIn),
    .LetterOut  (LetterOut),
    .LetterValid(LetterValid),
    .LetterError(LetterError),
    .Busy       (Busy)
  );

  string tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  bit         strict;
  bit         mBusy;
  bit         mBad;
  int         mRun;
  int         mZeros;
  int         mQuiet;
  string      mSyms;
  logic [2:0] mLetter;
  logic       mValid;
  logic       mError;

  function void modelReset();
    mBusy = 0; mBad = 0; mRun = 0; mZeros = 0; mQuiet = 0; mSyms = "";
    mLetter = 3'b000; mValid = 1'b0; mError = 1'b0;
  endfunction

  function void closeRun();
    if (mSyms.len() >= 4)  mBad = 1;
    else if (mRun == 1)    mSyms = {mSyms, "."};
    else if (mRun == 3)    mSyms = {mSyms, "-"};
    else begin
      mBad  = 1;
      mSyms = {mSyms, "?"};
    end
    mRun = 0;
  endfunction

  function void finishLetter();
    int found;
    found = -1;
    for (int i = 0; i < 8; i++) if (mSyms == tbl[i]) found = i;
    if (mBad || found < 0) mError = 1'b1;
    else begin
      mValid  = 1'b1;
      mLetter = found[2:0];
    end
    mBusy = 0; mBad = 0; mRun = 0; mZeros = 0; mQuiet = 0; mSyms = "";
  endfunction

  function void modelStep(input logic strobe, input logic b);
    mValid = 1'b0;
    mError = 1'b0;
    if (!mBusy) begin
      if (strobe && b) begin
        mBusy = 1; mRun = 1; mZeros = 0; mQuiet = 0;
      end
    end else if (strobe) begin
      mQuiet = 0;
      if (b) begin
        if (mRun > 0) mRun++;
        else begin
          if (mZeros == 2 && strict) mBad = 1;
          mRun   = 1;
          mZeros = 0;
        end
      end else if (mRun > 0) begin
        closeRun();
        mZeros = 1;
      end else begin
        mZeros++;
        if (mZeros == 3) finishLetter();
      end
    end else begin
      mQuiet++;
      if (mQuiet == T) begin
        if (mRun > 0) closeRun();
        finishLetter();
      end
    end
  endfunction

  task automatic checkOne(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("LetterOut",   LetterOut,           mLetter);
    checkOne("LetterValid", {2'b00, LetterValid}, {2'b00, mValid});
    checkOne("LetterError", {2'b00, LetterError}, {2'b00, mError});
    checkOne("Busy",        {2'b00, Busy},        {2'b00, mBusy});
  endtask

  task automatic applyStimulus(input logic strobe, input logic b);
    NewBitIn  = strobe;
    DotDashIn = b;
    @(posedge clk);
    modelStep(strobe, b);
    #1;
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
    checkOutput();
  endtask

  task automatic applyReset();
    Resetn    = 1'b0;
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
    #2;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    Resetn = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendBits(input string s, input bit jitter);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(1'b1, s[i] == "1");
      if (jitter) idleCycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    string bits;
    string pat;
    int    k;
`ifdef MORSE_DEC_STRICT_GAP_EN
    strict = 1;
`else
    strict = 0;
`endif
    Resetn    = 1'b0;
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    applyReset();
    idleCycles(2 * T);

    sendBits("10111000", 0);
    idleCycles(3);

    sendBits("111010111010", 0);
    idleCycles(T + 2);

    sendBits("11000", 0);
    idleCycles(2);

    sendBits("101010101000", 0);
    sendBits("1000", 0);
    idleCycles(2);

    sendBits("1110", 0);
    applyReset();
    sendBits("1000", 0);
    idleCycles(2);
    sendBits("100111000", 0);
    idleCycles(2);

    sendBits("1111101000", 0);
    sendBits("1", 0);
    idleCycles(T + 1);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 10);
      if (k < 8)       pat = tbl[k];
      else if (k == 8) pat = "--.-";
      else if (k == 9) pat = ".=.";
      else             pat = ".....";
      bits = "";
      for (int i = 0; i < pat.len(); i++) begin
        if (i > 0) bits = {bits, ($urandom_range(0, 4) == 0) ? "00" : "0"};
        if (pat[i] == ".")      bits = {bits, "1"};
        else if (pat[i] == "-") bits = {bits, "111"};
        else                    bits = {bits, "11"};
      end
      if ($urandom_range(0, 2) == 0) begin
        bits = {bits, "0"};
        sendBits(bits, 1);
        idleCycles(T + 1);
      end else begin
        bits = {bits, "000"};
        sendBits(bits, 1);
        idleCycles($urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
